// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmitter.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; count disambiguates full from empty.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == CW'(0));
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_wr && !do_rd) begin
                count <= count + CW'(1);
            end else if (!do_wr && do_rd) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART serialiser fed by a FIFO; frames go out back-to-back while words are queued.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS);

    if (PARITY > PAR_ODD) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY=%0d is illegal", PARITY);
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS=%0d is illegal", STOP_BITS);
    end

    tx_state_e             state;
    logic [CW-1:0]         clk_cnt;
    logic [IW-1:0]         bit_idx;
    logic [DATA_BITS-1:0]  shift;
    logic                  par_bit;

    logic [DATA_BITS-1:0]  head;
    logic                  full;
    logic                  empty;
    logic                  wr_en;
    logic                  pop_c;
    logic                  bit_last_c;
    logic                  stop_last_c;
    logic                  par_calc_c;
    logic                  tx_next_c;

    assign in_ready    = !full;
    assign wr_en       = in_valid && !full;
    assign bit_last_c  = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign stop_last_c = (bit_idx == IW'(STOP_BITS - 1));
    assign par_calc_c  = (PARITY == PAR_ODD) ? ~(^head) : ^head;
    assign pop_c       = !empty && ((state == ST_IDLE) ||
                                    (state == ST_STOP && bit_last_c && stop_last_c));

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (in_data),
        .rd_en   (pop_c),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    // Line level for the current state; registered below, so tx trails state by one cycle.
    always_comb begin
        tx_next_c = 1'b1;
        case (state)
            ST_START:  tx_next_c = 1'b0;
            ST_DATA:   tx_next_c = shift[0];
            ST_PARITY: tx_next_c = par_bit;
            default:   tx_next_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx      <= tx_next_c;
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop_c) begin
                        shift   <= head;
                        par_bit <= par_calc_c;
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= ST_START;
                        tx_busy <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_last_c) begin
                        clk_cnt <= '0;
                        state   <= ST_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_last_c) begin
                        clk_cnt <= '0;
                        shift   <= shift >> 1;
                        if (bit_idx == IW'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                ST_PARITY: begin
                    if (bit_last_c) begin
                        clk_cnt <= '0;
                        state   <= ST_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    // bit_idx counts stop bits here; a queued word restarts without an idle gap.
                    if (bit_last_c) begin
                        clk_cnt <= '0;
                        if (stop_last_c) begin
                            bit_idx <= '0;
                            tx_done <= 1'b1;
                            if (pop_c) begin
                                shift   <= head;
                                par_bit <= par_calc_c;
                                state   <= ST_START;
                            end else begin
                                state   <= ST_IDLE;
                                tx_busy <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
